// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver front end: two-flop synchronizer, mid-bit sampling FSM and a one-deep
// holding register with a valid/ready handshake plus sticky frame and overrun flags.
module uart_rx_frontend #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx,
  input  logic       rx_ready,
  input  logic       err_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q;
  logic            rx_s;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;

  logic tick, shift_en, deliver, frame_set, transfer, overrun_set;

  assign rx_s = sync_q[1];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; dropping ena always returns to idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (!rx_s) state_d = StStart;
      StStart:    if (tick) state_d = rx_s ? StIdle : StData;
      StData:     if (tick && bit_idx_q == 3'd7) state_d = StStop;
      StStop:     if (tick) state_d = rx_s ? StIdle : StWaitHigh;
      StWaitHigh: if (rx_s) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
    if (!ena) state_d = StIdle;
  end

  // FSM outputs: sample strobes and frame outcome.
  always_comb begin
    tick      = 1'b0;
    shift_en  = 1'b0;
    deliver   = 1'b0;
    frame_set = 1'b0;
    unique case (state_q)
      StStart: tick = (cnt_q == HalfLast);
      StData: begin
        tick     = (cnt_q == BitLast);
        shift_en = tick && ena;
      end
      StStop: begin
        tick      = (cnt_q == BitLast);
        deliver   = tick && ena && rx_s;
        frame_set = tick && ena && !rx_s;
      end
      default: tick = 1'b0;
    endcase
  end

  assign transfer    = rx_valid_q && rx_ready;
  assign overrun_set = deliver && rx_valid_q && !rx_ready;

  always_comb begin
    cnt_d       = cnt_q + CntW'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;

    if (!ena || tick || state_q == StIdle || state_q == StWaitHigh) cnt_d = '0;
    if (!ena || state_q == StIdle) begin
      bit_idx_d = 3'd0;
      shift_d   = 8'h00;
    end else if (shift_en) begin
      bit_idx_d = bit_idx_q + 3'd1;
      shift_d   = {rx_s, shift_q[7:1]};
    end

    // A delivery on a transfer edge refills the holder; otherwise a full holder drops it.
    if (deliver && (!rx_valid_q || rx_ready)) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
    end else if (transfer) begin
      rx_valid_d = 1'b0;
    end

    if (frame_set) begin
      frame_err_d = 1'b1;
    end else if (err_clr) begin
      frame_err_d = 1'b0;
    end
    if (overrun_set) begin
      overrun_d = 1'b1;
    end else if (err_clr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 2'b11;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rx};
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
